// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1-style serial transmitter with a start/busy handshake.
// Sends a start bit (0), DATA_BITS data bits LSB first and a stop bit (1).
// Each bit lasts BIT_PERIOD clocks. The line idles high.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
// All outputs are registered: they are loaded from the next-state values,
// so they change on the same edge as the state they describe.
module uart_tx_frame #(
  parameter int BIT_PERIOD = 10,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = $clog2(BIT_PERIOD);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state, state_n;
  logic [TW-1:0]          timer, timer_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   line_n, done_n, tc;
`ifdef UART_TX_PARITY_EN
  logic                   par, par_n;
`endif

  // State, counters, payload and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      shreg      <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      serial_out <= line_n;
      tx_busy    <= (state_n != IDLE);
      tx_done    <= done_n;
`ifdef UART_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  // Next-state logic, bit timing and next line level.
  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    shreg_n = shreg;
    line_n  = 1'b1;
    tc      = (timer == T_LAST);
    done_n  = (state == STOP) && tc;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif

    // Timer runs in every non-idle state and wraps on terminal count.
    if (state != IDLE) timer_n = tc ? '0 : timer + TW'(1);

    case (state)
      IDLE: begin
        timer_n = '0;
        idx_n   = '0;
        // tx_start is only looked at here, so requests while busy are dropped.
        if (tx_start) begin
          shreg_n = tx_data;
          state_n = START;
`ifdef UART_TX_PARITY_EN
          par_n   = ^tx_data;
`endif
        end
      end
      START: if (tc) state_n = DATA;
      DATA: begin
        if (tc) begin
          shreg_n = shreg >> 1;
          if (idx == I_LAST) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tc) state_n = STOP;
`endif
      STOP: if (tc) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Line level for the state we are entering.
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_n = par_n;
`endif
      default: line_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame with an abstract frame model.
module tb_uart_tx_frame;

  localparam int BP = 10;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DB + 3;
`else
  localparam int NB = DB + 2;
`endif
  localparam int FL = NB * BP;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          tx_start = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          serial_out, tx_busy, tx_done;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;   // edges seen; at a negedge this is the current cycle number
  int fstart = -1;  // edge at which the model accepted the current frame
  logic [DB-1:0] fdata = '0;

  uart_tx_frame #(.BIT_PERIOD(BP), .DATA_BITS(DB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
    .serial_out(serial_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, ecnt);
    end
  endtask

  // Frame bit i: 0 start, 1..DB data LSB first, optional parity, then stop.
  function automatic logic bit_at(input int i, input logic [DB-1:0] d);
    if (i == 0) return 1'b0;
    if (i <= DB) return d[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == DB + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Model acceptance: a request at edge e is taken when cycle e is not busy.
  always @(posedge clk) begin
    if (!n_rst) fstart = -1;
    else if (tx_start && !(fstart >= 0 && ecnt <= fstart + FL)) begin
      fstart = ecnt;
      fdata  = tx_data;
    end
    ecnt++;
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int c;
    logic eb, ed, es;
    c  = ecnt;
    eb = 1'b0; ed = 1'b0; es = 1'b1;
    if (n_rst && fstart >= 0) begin
      eb = (c >= fstart + 1) && (c <= fstart + FL);
      ed = (c == fstart + FL + 1);
      if (eb) es = bit_at((c - fstart - 1) / BP, fdata);
    end
    chk("model_serial", serial_out, es);
    chk("model_busy", tx_busy, eb);
    chk("model_done", tx_done, ed);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dones, rl;
    int mid_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int mid_3c[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};

    // Reset and idle.
    #2 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_serial", serial_out, 1);
      chk("idle_busy", tx_busy, 0);
      chk("idle_done", tx_done, 0);
    end
    #1;

`ifndef UART_TX_PARITY_EN
    // Single 0xA5 frame.
    k = ecnt; tx_data = 8'hA5; tx_start = 1'b1; dones = 0;
    for (int r = 1; r <= 101; r++) begin
      @(negedge clk);
      if (r % 10 == 5) chk("a5_mid", serial_out, mid_a5[r/10]);
      if (r == 1)   chk("a5_busy_first", tx_busy, 1);
      if (r == 100) chk("a5_busy_last", tx_busy, 1);
      if (r == 101) chk("a5_busy_after", tx_busy, 0);
      dones += tx_done;
      #1 tx_start = 1'b0;
    end
    chk("a5_done_last", tx_done, 1);
    chk("a5_done_count", dones, 1);

    // Same frame with a request and data churn during transmission.
    k = ecnt; tx_data = 8'hA5; tx_start = 1'b1; dones = 0;
    for (int r = 1; r <= 110; r++) begin
      @(negedge clk);
      if (r % 10 == 5 && r <= 95) chk("churn_mid", serial_out, mid_a5[r/10]);
      dones += tx_done;
      #1;
      tx_start = (r == 40);
      tx_data  = (r == 40) ? 8'hFF : DB'($urandom);
    end
    chk("churn_done_count", dones, 1);

    // tx_start held high: back-to-back 0x00 then 0xFF.
    k = ecnt; tx_data = 8'h00; tx_start = 1'b1;
    for (int r = 1; r <= 205; r++) begin
      @(negedge clk);
      if (r == 101) begin
        chk("b2b_gap_serial", serial_out, 1);
        chk("b2b_gap_done", tx_done, 1);
      end
      if (r == 102 || r == 111) chk("b2b_start2", serial_out, 0);
      if (r >= 117 && r <= 187 && (r - 117) % 10 == 0) chk("b2b_ff_mid", serial_out, 1);
      if (r == 201) chk("b2b_busy2_last", tx_busy, 1);
      if (r == 202) chk("b2b_done2", tx_done, 1);
      #1;
      if (r == 1) tx_data = 8'hFF;
      if (r == 150) tx_start = 1'b0;
    end

    // Reset during data bit 3, then a clean 0x3C frame.
    k = ecnt; tx_data = 8'hA5; tx_start = 1'b1; dones = 0;
    for (int r = 1; r <= 160; r++) begin
      @(negedge clk);
      dones += tx_done;
      #1 tx_start = 1'b0;
      if (r == 45) begin
        n_rst = 1'b0;
        #1;
        chk("rst_serial_now", serial_out, 1);
        chk("rst_busy_now", tx_busy, 0);
      end
      if (r == 47) n_rst = 1'b1;
    end
    chk("rst_no_done", dones, 0);
    k = ecnt; tx_data = 8'h3C; tx_start = 1'b1;
    for (int r = 1; r <= 101; r++) begin
      @(negedge clk);
      if (r % 10 == 5) chk("x3c_mid", serial_out, mid_3c[r/10]);
      if (r == 101) chk("x3c_done", tx_done, 1);
      #1 tx_start = 1'b0;
    end
`else
    // Parity build: 0x07 has odd weight, so the parity bit is 1.
    k = ecnt; tx_data = 8'h07; tx_start = 1'b1;
    for (int r = 1; r <= 111; r++) begin
      @(negedge clk);
      if (r == 91 || r == 100) chk("par_bit", serial_out, 1);
      if (r == 101 || r == 110) chk("par_stop", serial_out, 1);
      if (r == 110) chk("par_busy_last", tx_busy, 1);
      if (r == 111) chk("par_done", tx_done, 1);
      #1 tx_start = 1'b0;
    end
`endif

    // Random traffic with occasional resets; the model checks every cycle.
    rl = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      tx_start = ($urandom % 6 == 0);
      tx_data  = DB'($urandom);
      if (rl > 0) begin
        rl--;
        if (rl == 0) n_rst = 1'b1;
      end else if ($urandom % 400 == 0) begin
        n_rst = 1'b0;
        rl = 2;
      end
    end
    n_rst = 1'b1; tx_start = 1'b0;
    repeat (FL + 5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
